// File: rtl/player_state_controller.sv
// Player life/stun/invulnerability controller driven by per-frame pulses.
// Optional macro PLAYER_CTRL_EXTRA_LIFE_EN enables the extra_life_req bonus input.
module player_state_controller #(
  parameter int NUM_SOURCES     = 3,
  parameter int LIVES_WIDTH     = 3,
  parameter int START_LIVES     = 3,
  parameter int MAX_LIVES       = 7,
  parameter int HIT_FRAMES      = 8,
  parameter int INVULN_FRAMES   = 30,
  parameter int FRAME_CNT_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           enable,
  input  logic                           startOfFrame,
  input  logic [NUM_SOURCES-1:0]         damage_req,
  input  logic                           extra_life_req,
  output logic [NUM_SOURCES-1:0]         damage_ack,
  output logic [$clog2(NUM_SOURCES)-1:0] hit_source,
  output logic [LIVES_WIDTH-1:0]         lives,
  output logic                           player_faded,
  output logic                           controls_en,
  output logic                           player_dead
);

  localparam int SRC_W = $clog2(NUM_SOURCES);
  localparam logic [LIVES_WIDTH-1:0]     LIVES_ONE   = LIVES_WIDTH'(1);
  localparam logic [LIVES_WIDTH-1:0]     LIVES_MAX   = LIVES_WIDTH'(MAX_LIVES);
  localparam logic [LIVES_WIDTH-1:0]     LIVES_START = LIVES_WIDTH'(START_LIVES);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_ONE     = FRAME_CNT_WIDTH'(1);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_HIT     = FRAME_CNT_WIDTH'(HIT_FRAMES);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_INVULN  = FRAME_CNT_WIDTH'(INVULN_FRAMES);

  typedef enum logic [1:0] {ALIVE, HIT, INVULN, DEAD} state_t;

  state_t                     state_q, state_d;
  logic [LIVES_WIDTH-1:0]     lives_q, lives_d;
  logic [FRAME_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_SOURCES-1:0]     ack_q, ack_d;
  logic [SRC_W-1:0]           src_q, src_d;
  logic                       faded_q, faded_d;
  logic                       ctrl_q, ctrl_d;
  logic                       dead_q, dead_d;

  logic                       extra_en;
  logic                       grant_valid;
  logic [SRC_W-1:0]           grant_idx;
  logic [NUM_SOURCES-1:0]     grant_oh;

`ifdef PLAYER_CTRL_EXTRA_LIFE_EN
  assign extra_en = extra_life_req;
`else
  logic unused_extra_life;
  assign unused_extra_life = extra_life_req;
  assign extra_en = 1'b0;
`endif

  // Lowest set index wins, so scan downward and let later hits overwrite.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (damage_req[i]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(i);
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    src_d   = src_q;
    if (enable) begin
      if (extra_en && state_q != DEAD) begin
        lives_d = (lives_q >= LIVES_MAX) ? LIVES_MAX : lives_q + LIVES_ONE;
      end
      case (state_q)
        ALIVE: begin
          if (grant_valid) begin
            ack_d = grant_oh;
            src_d = grant_idx;
            // A coinciding bonus life cancels the loss, so the player survives even at one life.
            if (extra_en) begin
              lives_d = lives_q;
              cnt_d   = CNT_HIT;
              state_d = HIT;
            end else if (lives_q > LIVES_ONE) begin
              lives_d = lives_q - LIVES_ONE;
              cnt_d   = CNT_HIT;
              state_d = HIT;
            end else begin
              lives_d = '0;
              state_d = DEAD;
            end
          end
        end
        HIT: begin
          if (startOfFrame) begin
            if (cnt_q <= CNT_ONE) begin
              cnt_d   = CNT_INVULN;
              state_d = INVULN;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        INVULN: begin
          if (startOfFrame) begin
            if (cnt_q <= CNT_ONE) begin
              cnt_d   = '0;
              state_d = ALIVE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    faded_d = 1'b0;
    ctrl_d  = 1'b1;
    dead_d  = 1'b0;
    case (state_d)
      HIT: begin
        faded_d = 1'b1;
        ctrl_d  = 1'b0;
      end
      INVULN: faded_d = cnt_d[2];
      DEAD: begin
        faded_d = 1'b1;
        ctrl_d  = 1'b0;
        dead_d  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ALIVE;
      lives_q <= LIVES_START;
      cnt_q   <= '0;
      ack_q   <= '0;
      src_q   <= '0;
      faded_q <= 1'b0;
      ctrl_q  <= 1'b1;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      src_q   <= src_d;
      faded_q <= faded_d;
      ctrl_q  <= ctrl_d;
      dead_q  <= dead_d;
    end
  end

  assign damage_ack   = ack_q;
  assign hit_source   = src_q;
  assign lives        = lives_q;
  assign player_faded = faded_q;
  assign controls_en  = ctrl_q;
  assign player_dead  = dead_q;

endmodule

// File: tb/tb_player_state_controller.sv
// Scoreboard bench for player_state_controller: stimulus queues expected ack-cycle
// outputs, a negedge monitor pops and compares whenever damage_ack is non-zero.
module tb_player_state_controller;

  logic       clk = 1'b0;
  logic       resetN;
  logic       enable;
  logic       startOfFrame;
  logic [2:0] damage_req;
  logic       extra_life_req;
  logic [2:0] damage_ack;
  logic [1:0] hit_source;
  logic [2:0] lives;
  logic       player_faded;
  logic       controls_en;
  logic       player_dead;

  typedef struct {
    logic [2:0] ack;
    logic [1:0] src;
    logic [2:0] lives;
    logic       faded;
    logic       ctrl;
    logic       dead;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  player_state_controller dut (
    .clk            (clk),
    .resetN         (resetN),
    .enable         (enable),
    .startOfFrame   (startOfFrame),
    .damage_req     (damage_req),
    .extra_life_req (extra_life_req),
    .damage_ack     (damage_ack),
    .hit_source     (hit_source),
    .lives          (lives),
    .player_faded   (player_faded),
    .controls_en    (controls_en),
    .player_dead    (player_dead)
  );

  always #5 clk = ~clk;

  // Shared comparison point for the monitor and the directed checks.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sofPulse();
    startOfFrame = 1'b1;
    cycle();
    startOfFrame = 1'b0;
    cycle();
  endtask

  task automatic runOut();
    for (int i = 0; i < 38; i++) sofPulse();
    checkOutput("alive_faded", int'(player_faded), 0);
    checkOutput("alive_ctrl", int'(controls_en), 1);
  endtask

  task automatic doReset();
    resetN = 1'b0;
    cycle();
    cycle();
    resetN = 1'b1;
    cycle();
  endtask

  task automatic applyStimulus(input logic [2:0] req, input logic extra, input exp_t e);
    damage_req     = req;
    extra_life_req = extra;
    exp_q.push_back(e);
    cycle();
    damage_req     = '0;
    extra_life_req = 1'b0;
    cycle();
  endtask

  function automatic exp_t mk(input logic [2:0] a, input logic [1:0] s, input logic [2:0] l,
                              input logic f, input logic c, input logic d);
    exp_t e;
    e.ack = a; e.src = s; e.lives = l; e.faded = f; e.ctrl = c; e.dead = d;
    return e;
  endfunction

  // Monitor: every ack pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetN === 1'b1 && damage_ack !== 3'b000) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_ack", int'(damage_ack), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("ack", int'(damage_ack), int'(e.ack));
        checkOutput("hit_source", int'(hit_source), int'(e.src));
        checkOutput("ack_lives", int'(lives), int'(e.lives));
        checkOutput("ack_faded", int'(player_faded), int'(e.faded));
        checkOutput("ack_ctrl", int'(controls_en), int'(e.ctrl));
        checkOutput("ack_dead", int'(player_dead), int'(e.dead));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b0; enable = 1'b1; startOfFrame = 1'b0;
    damage_req = '0; extra_life_req = 1'b0;
    #12;
    checkOutput("rst_lives", int'(lives), 3);
    checkOutput("rst_ack", int'(damage_ack), 0);
    checkOutput("rst_src", int'(hit_source), 0);
    checkOutput("rst_faded", int'(player_faded), 0);
    checkOutput("rst_ctrl", int'(controls_en), 1);
    checkOutput("rst_dead", int'(player_dead), 0);
    cycle();
    resetN = 1'b1;
    cycle();

    // First hit: bit 1 wins over bit 2.
    applyStimulus(3'b110, 1'b0, mk(3'b010, 2'd1, 3'd2, 1'b1, 1'b0, 1'b0));
    damage_req = 3'b001;
    for (int k = 1; k <= 7; k++) begin
      sofPulse();
      checkOutput("hit_faded", int'(player_faded), 1);
      checkOutput("hit_ctrl", int'(controls_en), 0);
    end
    sofPulse();
    checkOutput("invuln_entry_ctrl", int'(controls_en), 1);
    checkOutput("invuln_entry_faded", int'(player_faded), 1);
    for (int k = 1; k <= 29; k++) begin
      sofPulse();
      checkOutput("invuln_faded", int'(player_faded), ((30 - k) >> 2) & 1);
      checkOutput("invuln_ctrl", int'(controls_en), 1);
    end
    damage_req = '0;
    sofPulse();
    checkOutput("back_alive_faded", int'(player_faded), 0);
    checkOutput("back_alive_lives", int'(lives), 2);

    // Freeze mid-HIT, then async reset mid-INVULN.
    applyStimulus(3'b100, 1'b0, mk(3'b100, 2'd2, 3'd1, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) sofPulse();
    enable = 1'b0; startOfFrame = 1'b1; damage_req = 3'b111; extra_life_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput("frz_ack", int'(damage_ack), 0);
    end
    checkOutput("frz_lives", int'(lives), 1);
    checkOutput("frz_faded", int'(player_faded), 1);
    checkOutput("frz_ctrl", int'(controls_en), 0);
    enable = 1'b1; startOfFrame = 1'b0; damage_req = '0; extra_life_req = 1'b0;
    cycle();
    for (int k = 0; k < 4; k++) sofPulse();
    checkOutput("frz_still_hit", int'(controls_en), 0);
    sofPulse();
    checkOutput("frz_invuln", int'(controls_en), 1);
    checkOutput("frz_invuln_faded", int'(player_faded), 1);
    resetN = 1'b0;
    #1;
    checkOutput("async_lives", int'(lives), 3);
    checkOutput("async_faded", int'(player_faded), 0);
    checkOutput("async_ctrl", int'(controls_en), 1);
    cycle();
    resetN = 1'b1;
    for (int k = 0; k < 3; k++) cycle();

    // Extra life during HIT.
    applyStimulus(3'b010, 1'b0, mk(3'b010, 2'd1, 3'd2, 1'b1, 1'b0, 1'b0));
    extra_life_req = 1'b1;
    cycle();
    extra_life_req = 1'b0;
    cycle();
`ifdef PLAYER_CTRL_EXTRA_LIFE_EN
    checkOutput("extra_in_hit", int'(lives), 3);
`else
    checkOutput("extra_ignored", int'(lives), 2);
`endif

    // Three hits from three lives end the game.
    doReset();
    applyStimulus(3'b001, 1'b0, mk(3'b001, 2'd0, 3'd2, 1'b1, 1'b0, 1'b0));
    runOut();
    applyStimulus(3'b010, 1'b0, mk(3'b010, 2'd1, 3'd1, 1'b1, 1'b0, 1'b0));
    runOut();
    applyStimulus(3'b100, 1'b0, mk(3'b100, 2'd2, 3'd0, 1'b1, 1'b0, 1'b1));
    damage_req = 3'b111; extra_life_req = 1'b1;
    for (int k = 0; k < 4; k++) sofPulse();
    damage_req = '0; extra_life_req = 1'b0;
    cycle();
    checkOutput("dead_lives", int'(lives), 0);
    checkOutput("dead_flag", int'(player_dead), 1);
    checkOutput("dead_faded", int'(player_faded), 1);
    checkOutput("dead_ctrl", int'(controls_en), 0);
    checkOutput("dead_src", int'(hit_source), 2);

`ifdef PLAYER_CTRL_EXTRA_LIFE_EN
    doReset();
    for (int k = 0; k < 7; k++) begin
      extra_life_req = 1'b1;
      cycle();
      extra_life_req = 1'b0;
      cycle();
    end
    checkOutput("extra_saturate", int'(lives), 7);
    doReset();
    applyStimulus(3'b001, 1'b0, mk(3'b001, 2'd0, 3'd2, 1'b1, 1'b0, 1'b0));
    runOut();
    applyStimulus(3'b001, 1'b0, mk(3'b001, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0));
    runOut();
    applyStimulus(3'b001, 1'b1, mk(3'b001, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0));
    checkOutput("extra_grant_hit", int'(controls_en), 0);
    checkOutput("extra_grant_alive", int'(player_dead), 0);
`endif

    for (int k = 0; k < 5; k++) cycle();
    checkOutput("pending_acks", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/player_state_controller.md
PLAYER_STATE_CONTROLLER -- requirements
Module: player_state_controller

Interface
REQ-001 Parameters: NUM_SOURCES, default 3, number of damage requesters; LIVES_WIDTH, default 3, lives counter width; START_LIVES, default 3, lives after reset; MAX_LIVES, default 7, extra-life saturation value; HIT_FRAMES, default 8, stun length in frames; INVULN_FRAMES, default 30, invulnerability length in frames; FRAME_CNT_WIDTH, default 6, frame counter width.
REQ-002 Ports:
- clk  in  1  clock
- resetN  in  1  reset, asynchronous, active-low
- enable  in  1  advance when high, freeze when low
- startOfFrame  in  1  one-cycle pulse per video frame
- damage_req  in  NUM_SOURCES  level damage requests; bit 0 has highest priority
- extra_life_req  in  1  one-cycle bonus-life pulse
- damage_ack  out  NUM_SOURCES  one-hot grant pulse
- hit_source  out  $clog2(NUM_SOURCES)  index of the last granted source
- lives  out  LIVES_WIDTH  current lives
- player_faded  out  1  draw player faded
- controls_en  out  1  player movement/fire allowed
- player_dead  out  1  game-over flag

Function
REQ-003 FSM states: ALIVE, HIT, INVULN, DEAD.
REQ-004 All state, counter and output updates occur only in cycles where enable=1; with enable=0 every register holds its value and damage_ack is 0.
REQ-005 ALIVE: if any damage_req bit is set, grant the lowest set index; damage_ack shows that one-hot bit for exactly one cycle, registered, in the cycle after the request is sampled; hit_source is updated in that same cycle.
REQ-006 On a grant with lives>1 (after the REQ-010 adjustment): lives decrements by 1, frame counter loads HIT_FRAMES, next state is HIT.
REQ-007 On a grant with lives==1 and no simultaneous extra life: lives becomes 0, next state is DEAD.
REQ-008 HIT: the frame counter decrements on each startOfFrame; when it reaches 0 it loads INVULN_FRAMES and the next state is INVULN. Damage requests are ignored (no ack).
REQ-009 INVULN: the frame counter decrements on each startOfFrame; when it reaches 0 the next state is ALIVE. Damage requests are ignored (no ack).
REQ-010 Extra life (see REQ-016): in any state except DEAD, lives increments, saturating at MAX_LIVES. When it coincides with a grant, the net lives change is 0 and the FSM still enters HIT, including when lives==1.
REQ-011 DEAD is terminal until reset; all requests are ignored.
REQ-012 Outputs, registered from state:
- ALIVE: faded=0, controls_en=1, dead=0.
- HIT: faded=1, controls_en=0, dead=0.
- INVULN: faded = frame counter bit 2, controls_en=1, dead=0.
- DEAD: faded=1, controls_en=0, dead=1.
REQ-013 Arithmetic: all counter arithmetic is truncated to its declared width; lives never wraps below 0 or above MAX_LIVES.

Reset
REQ-014 resetN low asynchronously forces: state=ALIVE, lives=START_LIVES, frame counter=0, damage_ack=0, hit_source=0, player_faded=0, controls_en=1, player_dead=0.
REQ-015 Reset asserted mid-HIT or mid-INVULN abandons the sequence and produces no ack pulse after reset release.

Configuration
REQ-016 Macro PLAYER_CTRL_EXTRA_LIFE_EN:
- Defined: extra_life_req is honoured per REQ-010.
- Undefined: extra_life_req is ignored; the port remains present and lives can only decrease.

Verification
REQ-017 Reset, then damage_req=3'b110 for one cycle -> damage_ack=3'b010 for one cycle, hit_source=1, lives 3->2, faded=1, controls_en=0.
REQ-018 After the hit, 8 startOfFrame pulses -> INVULN entered; faded follows frame counter bit 2 for 30 frames; damage_req held high during HIT/INVULN produces no ack; then ALIVE with faded=0.
REQ-019 Three spaced hits from 3 lives -> lives=0, player_dead=1, faded=1, controls_en=0; further requests and extra lives are ignored until reset.
REQ-020 With the macro defined, lives=1 and damage_req plus extra_life_req in the same cycle -> lives stays 1, state HIT, ack issued; 7 extra lives from 3 saturate at 7.
REQ-021 enable=0 mid-HIT with startOfFrame and damage pulses -> counter, lives and outputs frozen; resetN low mid-INVULN -> lives=3, ALIVE immediately.
REQ-022 Macro undefined, extra_life_req pulsed at lives=2 -> lives remains 2.
